sram_masked_controller: RTL and testbench
=========================================

# sram_masked_controller

Parametrised asynchronous-SRAM controller between the 32-bit request/ready system bus and an external SRAM of 8- or 16-bit data width. Splits each 32-bit access into SRAM beats with configurable per-beat cycle count, supports byte-masked writes via LB_n/UB_n and beat skipping, and deselects the chip when idle. It replaces the fixed 16-bit, fixed-timing controller on boards whose SRAM width or speed grade differs.

## Interface
Parameters:
- SRAM_ADDRESS_WIDTH, 18: SRAM address bits.
- SRAM_DATA_WIDTH, 16: SRAM data width; legal values are 8 and 16. BEATS = 32/SRAM_DATA_WIDTH.
- ACCESS_CYCLES, 3: clock cycles per beat; legal range is 3..15.

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_request  in  1  transaction request; held high until o_ready.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address; bits [1:0] are ignored.
- i_wdata  in  32  write data.
- i_wmask  in  4  write byte enables; bit n covers i_wdata[8n+7:8n].
- o_rdata  out  32  read data; valid while o_ready is high.
- o_ready  out  1  transaction complete.
- SRAM_A  out  SRAM_ADDRESS_WIDTH  SRAM address.
- SRAM_D_w  out  SRAM_DATA_WIDTH  SRAM write data.
- SRAM_D_r  in  SRAM_DATA_WIDTH  SRAM read data.
- SRAM_D_rw  out  1  data pad direction; 1 = drive.
- SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n  out  1 each  SRAM strobes, active-low.

## Operation
- FSM states: IDLE, BEAT, DONE. All SRAM-side outputs and o_ready/o_rdata are registered.
- IDLE:
  - Outputs: CE_n=1, OE_n=1, WE_n=1, D_rw=0.
  - On i_request=1, latch address, rw, wdata and wmask, then go to BEAT starting at the first enabled beat.
- BEAT b (0..BEATS-1), cycle c (0..ACCESS_CYCLES-1):
  - SRAM_A = {i_address[SRAM_ADDRESS_WIDTH+1-log2(BEATS):2], b[log2(BEATS)-1:0]}, truncated to SRAM_ADDRESS_WIDTH bits. It is held for the whole beat.
  - Beat b covers bits [SRAM_DATA_WIDTH*(b+1)-1 : SRAM_DATA_WIDTH*b].
  - CE_n=0 throughout.
- Read beat:
  - OE_n=0, D_rw=0, LB_n=UB_n=0.
  - SRAM_D_r is captured into the beat's slice of o_rdata at c=ACCESS_CYCLES-1.
- Write beat:
  - D_rw=1 and SRAM_D_w = the beat's slice of wdata, for all c.
  - WE_n=0 for c=1..ACCESS_CYCLES-2, giving one cycle of address setup and one cycle of hold.
  - 16-bit mode: LB_n=~wmask[2b], UB_n=~wmask[2b+1]. 8-bit mode: LB_n=UB_n=0.
  - Beats whose mask bits are all zero are skipped and consume zero cycles.
- After the last beat, go to DONE.
- DONE:
  - o_ready=1, CE_n=1, all strobes idle.
  - Stay in DONE while i_request=1. Return to IDLE the cycle after i_request=0.
- A write with wmask=0 goes IDLE→DONE directly.
- i_request dropping during BEAT is a protocol violation: the transaction completes, then DONE exits immediately.
- i_address, i_wdata and i_wmask changes after acceptance are ignored.

## Timing
- Reset (i_reset_n=0 at an edge) forces IDLE. It applies mid-transaction too; WE_n deasserts at that same edge.
- Reset values:
  - o_ready=0, o_rdata=0, SRAM_A=0, SRAM_D_w=0, SRAM_D_rw=0.
  - SRAM_CE_n=1, SRAM_OE_n=1, SRAM_WE_n=1, SRAM_LB_n=1, SRAM_UB_n=1.
  - Read-buffer valid cleared.
- Latency: request sampled at edge 0. BEAT outputs are visible after edge 1. o_ready is high after edge 1 + N·ACCESS_CYCLES, where N = beats performed.
  - Full read, 16-bit, ACCESS_CYCLES=3: o_ready after edge 7.
  - Full read, 8-bit, ACCESS_CYCLES=3: o_ready after edge 13.
- Back-to-back transactions need at least one cycle of i_request=0 (DONE→IDLE).

## Configuration
- SRAM_READ_BUFFER_EN defined:
  - A one-entry buffer holds the last read word and its word address.
  - A read hitting a valid entry goes IDLE→DONE with o_rdata from the buffer, so o_ready is high after edge 1, with no SRAM strobes.
  - A completed read loads the buffer.
  - Any write to the same word address, including wmask=0, invalidates the entry.
- SRAM_READ_BUFFER_EN undefined: no buffer; every read accesses the SRAM.

## Test plan
- Reset: i_reset_n=0 for 2 cycles → all outputs at reset values; CE_n=1.
- 16-bit read, ACCESS_CYCLES=3, addr 0x0000_0010, SRAM word 8=0x1234, word 9=0xABCD:
  - SRAM_A = 8 then 9.
  - o_rdata=0xABCD1234, o_ready after edge 7.
  - o_ready stays high while the request is held and drops one cycle after the request drops.
- 16-bit write, wdata 0xDEADBEEF, wmask 4'b0100:
  - Only beat 1 runs: SRAM_A=addr/2+1, D_w=0xDEAD, LB_n=0, UB_n=1, WE_n low for exactly 1 cycle.
  - o_ready after edge 4.
- 8-bit mode write, wmask 4'b1111 → 4 beats, SRAM_A low bits 0,1,2,3, D_w=0xEF,0xBE,0xAD,0xDE.
- Reset asserted at beat 0 cycle 1 of a write → WE_n=1 and CE_n=1 after that edge; a next read completes normally.
- SRAM_READ_BUFFER_EN defined:
  - Read A twice → second completes after edge 1 with CE_n held 1.
  - Write to A, then read A → full SRAM read.

Source files
------------

// File: rtl/sram_masked_controller_if.sv
// Bus + SRAM pin bundle for sram_masked_controller.
// Latency: none (wires only).
// Backpressure: the request side holds i_request until o_ready; slave = controller view, master = bus/SRAM side.
interface sram_masked_controller_if #(
   parameter int SRAM_ADDRESS_WIDTH = 18,
   parameter int SRAM_DATA_WIDTH    = 16
);
   // system bus
   logic                          i_request;
   logic                          i_rw;
   logic [31:0]                   i_address;
   logic [31:0]                   i_wdata;
   logic [3:0]                    i_wmask;
   logic [31:0]                   o_rdata;
   logic                          o_ready;
   // SRAM pins
   logic [SRAM_ADDRESS_WIDTH-1:0] SRAM_A;
   logic [SRAM_DATA_WIDTH-1:0]    SRAM_D_w;
   logic [SRAM_DATA_WIDTH-1:0]    SRAM_D_r;
   logic                          SRAM_D_rw;
   logic                          SRAM_CE_n;
   logic                          SRAM_OE_n;
   logic                          SRAM_WE_n;
   logic                          SRAM_LB_n;
   logic                          SRAM_UB_n;

   modport slave (
      input  i_request, i_rw, i_address, i_wdata, i_wmask, SRAM_D_r,
      output o_rdata, o_ready, SRAM_A, SRAM_D_w, SRAM_D_rw,
             SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n
   );

   modport master (
      output i_request, i_rw, i_address, i_wdata, i_wmask, SRAM_D_r,
      input  o_rdata, o_ready, SRAM_A, SRAM_D_w, SRAM_D_rw,
             SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n
   );
endinterface

// File: rtl/sram_masked_controller.sv
// Async-SRAM controller: splits 32-bit bus accesses into 8/16-bit beats with byte masks; optional SRAM_READ_BUFFER_EN.
// Latency: o_ready high after edge 1 + N*ACCESS_CYCLES (request edge = 0, N = beats run; N = 0 for empty mask or buffer hit).
// Backpressure: bus holds i_request until o_ready; DONE holds o_ready until the request drops, then returns to IDLE.
module sram_masked_controller #(
   parameter int SRAM_ADDRESS_WIDTH = 18,
   parameter int SRAM_DATA_WIDTH    = 16,
   parameter int ACCESS_CYCLES      = 3
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   sram_masked_controller_if.slave bus
);
   localparam int BEATS = 32 / SRAM_DATA_WIDTH;
   localparam int LOG2B = $clog2(BEATS);
   localparam int BPB   = SRAM_DATA_WIDTH / 8;
   localparam int AW    = SRAM_ADDRESS_WIDTH;
   localparam int DW    = SRAM_DATA_WIDTH;
   localparam int WBASE = AW - LOG2B;   // word-address bits placed above the beat index on SRAM_A
   localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

   state_t           state_q, state_d;
   logic [LOG2B-1:0] beat_q, beat_d;
   logic [3:0]       cyc_q, cyc_d;
   logic             pend_q, pend_d;    // request latched, transaction decision on the next edge
   logic             rw_q, rw_d;
   logic [29:0]      addr_q, addr_d;    // word address (byte address bits [31:2])
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic [AW-1:0]    a_q, a_d;
   logic [DW-1:0]    dw_q, dw_d;
   logic             drw_q, drw_d;
   logic             ce_q, ce_d;
   logic             oe_q, oe_d;
   logic             we_q, we_d;
   logic             lb_q, lb_d;
   logic             ub_q, ub_d;

`ifdef SRAM_READ_BUFFER_EN
   logic             buf_vld_q, buf_vld_d;
   logic [29:0]      buf_addr_q, buf_addr_d;
   logic [31:0]      buf_data_q, buf_data_d;
`endif

   logic [BEATS-1:0] en;
   logic [LOG2B:0]   nxt;               // {found, beat index}
   logic [BPB-1:0]   bm;

   // Byte-lane bits of the address and upper word bits beyond the SRAM are intentionally not decoded.
   logic unused_bits;
   assign unused_bits = ^{bus.i_address[1:0], addr_q[29:WBASE]};

   // Reads run every beat; writes only run beats with at least one enabled byte.
   function automatic logic [BEATS-1:0] beat_enables(input logic rw, input logic [3:0] mask);
      logic [BEATS-1:0] e;
      for (int b = 0; b < BEATS; b++) e[b] = rw ? |mask[b*BPB +: BPB] : 1'b1;
      return e;
   endfunction

   // Lowest enabled beat at or above 'from'; MSB of the result flags that one exists.
   function automatic logic [LOG2B:0] find_beat(input logic [BEATS-1:0] e, input int from);
      logic [LOG2B:0] r;
      r = '0;
      for (int i = BEATS - 1; i >= 0; i--) begin
         if (i >= from && e[i]) r = {1'b1, LOG2B'(i)};
      end
      return r;
   endfunction

   // Next-state logic, then registered pin values derived from the next state.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cyc_d   = cyc_q;
      pend_d  = pend_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      a_d     = a_q;
      dw_d    = dw_q;
      ready_d = 1'b0;
      drw_d   = 1'b0;
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      lb_d    = 1'b1;
      ub_d    = 1'b1;
      bm      = '0;
      nxt     = '0;
      en      = beat_enables(rw_q, wmask_q);
`ifdef SRAM_READ_BUFFER_EN
      buf_vld_d  = buf_vld_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
`endif

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               pend_d = 1'b0;
               nxt    = find_beat(en, 0);
`ifdef SRAM_READ_BUFFER_EN
               if (buf_vld_q && buf_addr_q == addr_q) begin
                  if (rw_q) begin
                     buf_vld_d = 1'b0;
                  end else begin
                     nxt     = '0;
                     rdata_d = buf_data_q;
                  end
               end
`endif
               if (nxt[LOG2B]) begin
                  state_d = BEAT;
                  beat_d  = nxt[LOG2B-1:0];
                  cyc_d   = 4'd0;
               end else begin
                  state_d = DONE;
               end
            end else if (bus.i_request) begin
               pend_d  = 1'b1;
               rw_d    = bus.i_rw;
               addr_d  = bus.i_address[31:2];
               wdata_d = bus.i_wdata;
               wmask_d = bus.i_wmask;
            end
         end
         BEAT: begin
            if (cyc_q == LAST_CYC) begin
               if (!rw_q) rdata_d[beat_q*DW +: DW] = bus.SRAM_D_r;
               nxt = find_beat(en, int'(beat_q) + 1);
               if (nxt[LOG2B]) begin
                  beat_d = nxt[LOG2B-1:0];
                  cyc_d  = 4'd0;
               end else begin
                  state_d = DONE;
`ifdef SRAM_READ_BUFFER_EN
                  if (!rw_q) begin
                     buf_vld_d  = 1'b1;
                     buf_addr_d = addr_q;
                     buf_data_d = rdata_d;
                  end
`endif
               end
            end else begin
               cyc_d = cyc_q + 4'd1;
            end
         end
         DONE: begin
            if (!bus.i_request) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         BEAT: begin
            ce_d = 1'b0;
            a_d  = {addr_d[WBASE-1:0], beat_d};
            if (rw_d) begin
               drw_d = 1'b1;
               dw_d  = wdata_d[beat_d*DW +: DW];
               // first and last cycle of the beat give address setup and hold around WE_n
               we_d  = (cyc_d == 4'd0) || (cyc_d == LAST_CYC);
               bm    = wmask_d[beat_d*BPB +: BPB];
               if (BPB == 2) begin
                  lb_d = ~bm[0];
                  ub_d = ~bm[BPB-1];
               end else begin
                  lb_d = 1'b0;
                  ub_d = 1'b0;
               end
            end else begin
               oe_d = 1'b0;
               lb_d = 1'b0;
               ub_d = 1'b0;
            end
         end
         DONE:    ready_d = 1'b1;
         default: ;
      endcase
   end

   // State and registered outputs; reset also returns the SRAM pins to deselected.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         cyc_q   <= '0;
         pend_q  <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         a_q     <= '0;
         dw_q    <= '0;
         drw_q   <= 1'b0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         lb_q    <= 1'b1;
         ub_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cyc_q   <= cyc_d;
         pend_q  <= pend_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         a_q     <= a_d;
         dw_q    <= dw_d;
         drw_q   <= drw_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         lb_q    <= lb_d;
         ub_q    <= ub_d;
      end
   end

`ifdef SRAM_READ_BUFFER_EN
   // One-entry read buffer: last read word and its word address.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         buf_vld_q  <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
      end else begin
         buf_vld_q  <= buf_vld_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
      end
   end
`endif

   assign bus.o_rdata   = rdata_q;
   assign bus.o_ready   = ready_q;
   assign bus.SRAM_A    = a_q;
   assign bus.SRAM_D_w  = dw_q;
   assign bus.SRAM_D_rw = drw_q;
   assign bus.SRAM_CE_n = ce_q;
   assign bus.SRAM_OE_n = oe_q;
   assign bus.SRAM_WE_n = we_q;
   assign bus.SRAM_LB_n = lb_q;
   assign bus.SRAM_UB_n = ub_q;
endmodule

// File: tb/tb_sram_masked_controller.sv
// Bench for sram_masked_controller: 16-bit and 8-bit instances sharing one bus driver, each with an SRAM model.
// Latency: checks the edge index at which o_ready first appears against hand-computed values.
// Backpressure: request held until o_ready, then dropped; o_ready must fall one edge later.
module tb_sram_masked_controller;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n    = 1'b0;
   logic        mem_init = 1'b1;
   logic        sel8     = 1'b0;
   logic        req      = 1'b0;
   logic        rw       = 1'b0;
   logic [31:0] addr     = '0;
   logic [31:0] wdata    = '0;
   logic [3:0]  wmask    = '0;

   logic [15:0] mem16 [0:63];
   logic [7:0]  mem8  [0:63];

   int checks = 0;
   int errors = 0;

   logic [17:0] a_q [$];
   logic [15:0] d_q [$];
   int          we_lo, ce_lo;
   logic        beat_lb, beat_ub, beat_drw;

   sram_masked_controller_if #(.SRAM_ADDRESS_WIDTH(18), .SRAM_DATA_WIDTH(16)) if16 ();
   sram_masked_controller_if #(.SRAM_ADDRESS_WIDTH(18), .SRAM_DATA_WIDTH(8))  if8 ();

   sram_masked_controller #(.SRAM_ADDRESS_WIDTH(18), .SRAM_DATA_WIDTH(16), .ACCESS_CYCLES(3)) dut16 (
      .i_clock(clk), .i_reset_n(rst_n), .bus(if16.slave));
   sram_masked_controller #(.SRAM_ADDRESS_WIDTH(18), .SRAM_DATA_WIDTH(8), .ACCESS_CYCLES(3)) dut8 (
      .i_clock(clk), .i_reset_n(rst_n), .bus(if8.slave));

   assign if16.i_request = req & ~sel8;
   assign if16.i_rw      = rw;
   assign if16.i_address = addr;
   assign if16.i_wdata   = wdata;
   assign if16.i_wmask   = wmask;
   assign if16.SRAM_D_r  = mem16[if16.SRAM_A[5:0]];
   assign if8.i_request  = req & sel8;
   assign if8.i_rw       = rw;
   assign if8.i_address  = addr;
   assign if8.i_wdata    = wdata;
   assign if8.i_wmask    = wmask;
   assign if8.SRAM_D_r   = mem8[if8.SRAM_A[5:0]];

   logic        mon_ce, mon_we, mon_lb, mon_ub, mon_drw, mon_ready;
   logic [17:0] mon_a;
   logic [15:0] mon_dw;
   logic [31:0] mon_rdata;
   assign mon_ce    = sel8 ? if8.SRAM_CE_n : if16.SRAM_CE_n;
   assign mon_we    = sel8 ? if8.SRAM_WE_n : if16.SRAM_WE_n;
   assign mon_lb    = sel8 ? if8.SRAM_LB_n : if16.SRAM_LB_n;
   assign mon_ub    = sel8 ? if8.SRAM_UB_n : if16.SRAM_UB_n;
   assign mon_drw   = sel8 ? if8.SRAM_D_rw : if16.SRAM_D_rw;
   assign mon_ready = sel8 ? if8.o_ready : if16.o_ready;
   assign mon_a     = sel8 ? if8.SRAM_A : if16.SRAM_A;
   assign mon_dw    = sel8 ? {8'h00, if8.SRAM_D_w} : if16.SRAM_D_w;
   assign mon_rdata = sel8 ? if8.o_rdata : if16.o_rdata;

   // Async SRAM models: byte-laned write while CE_n and WE_n are low.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem16[i] = 16'h0000;
            mem8[i]  = 8'h00;
         end
         mem16[8] = 16'h1234;
         mem16[9] = 16'hABCD;
      end else begin
         if (!if16.SRAM_CE_n && !if16.SRAM_WE_n) begin
            if (!if16.SRAM_LB_n) mem16[if16.SRAM_A[5:0]][7:0]  = if16.SRAM_D_w[7:0];
            if (!if16.SRAM_UB_n) mem16[if16.SRAM_A[5:0]][15:8] = if16.SRAM_D_w[15:8];
         end
         if (!if8.SRAM_CE_n && !if8.SRAM_WE_n) mem8[if8.SRAM_A[5:0]] = if8.SRAM_D_w;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One bus transaction; returns the edge index of the first o_ready and the read data.
   task automatic xact(input logic s8, input logic r_w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] wm, input int hold, output int edge_idx, output logic [31:0] rd);
      logic done;
      sel8 = s8; rw = r_w; addr = ad; wdata = wd; wmask = wm; req = 1'b1;
      a_q.delete(); d_q.delete();
      we_lo = 0; ce_lo = 0; done = 1'b0; edge_idx = -1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(posedge clk);
         edge_idx++;
         @(negedge clk);
         if (mon_ce == 1'b0) begin
            ce_lo++;
            if (a_q.size() == 0 || a_q[a_q.size()-1] != mon_a) begin
               a_q.push_back(mon_a);
               d_q.push_back(mon_dw);
               beat_lb  = mon_lb;
               beat_ub  = mon_ub;
               beat_drw = mon_drw;
            end
         end
         if (mon_we == 1'b0) we_lo++;
         if (mon_ready) done = 1'b1;
      end
      chk("ready_seen", {31'b0, done}, 32'd1);
      rd = mon_rdata;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("ready_hold", {31'b0, mon_ready}, 32'd1);
      end
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_drop", {31'b0, mon_ready}, 32'd0);
   endtask

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp_rdata;
      int          exp_edge;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          e;
      logic [31:0] rd;
      logic [7:0]  exp8 [4];

      vecs[0]  = '{1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0,        7};
      vecs[1]  = '{1'b0, 32'h20, 32'h0,        4'b0000, 32'h11223344, 7};
      vecs[2]  = '{1'b1, 32'h20, 32'hDEADBEEF, 4'b0100, 32'h0,        4};
      vecs[3]  = '{1'b0, 32'h20, 32'h0,        4'b0000, 32'h11AD3344, 7};
      vecs[4]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0,        1};
      vecs[5]  = '{1'b1, 32'h20, 32'hCAFEF00D, 4'b0011, 32'h0,        4};
      vecs[6]  = '{1'b0, 32'h20, 32'h0,        4'b0000, 32'h11ADF00D, 7};
      vecs[7]  = '{1'b1, 32'h20, 32'h55667788, 4'b1000, 32'h0,        4};
      vecs[8]  = '{1'b0, 32'h20, 32'h0,        4'b0000, 32'h55ADF00D, 7};
      vecs[9]  = '{1'b1, 32'h24, 32'h000000AA, 4'b0001, 32'h0,        4};
      vecs[10] = '{1'b0, 32'h24, 32'h0,        4'b0000, 32'h000000AA, 7};
      vecs[11] = '{1'b0, 32'h13, 32'h0,        4'b0000, 32'hABCD1234, 7};
      exp8 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, if16.o_ready}, 32'd0);
      chk("rst_rdata", if16.o_rdata, 32'd0);
      chk("rst_a", {14'b0, if16.SRAM_A}, 32'd0);
      chk("rst_dw", {16'b0, if16.SRAM_D_w}, 32'd0);
      chk("rst_drw", {31'b0, if16.SRAM_D_rw}, 32'd0);
      chk("rst_ce", {31'b0, if16.SRAM_CE_n}, 32'd1);
      chk("rst_oe", {31'b0, if16.SRAM_OE_n}, 32'd1);
      chk("rst_we", {31'b0, if16.SRAM_WE_n}, 32'd1);
      chk("rst_lb", {31'b0, if16.SRAM_LB_n}, 32'd1);
      chk("rst_ub", {31'b0, if16.SRAM_UB_n}, 32'd1);
      chk("rst_ce8", {31'b0, if8.SRAM_CE_n}, 32'd1);
      rst_n = 1'b1;
      mem_init = 1'b0;

      // 16-bit read of words 8/9, request held two extra cycles
      xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 2, e, rd);
      chk("rd16_edge", e, 32'd7);
      chk("rd16_data", rd, 32'hABCD1234);
      chk("rd16_nbeats", a_q.size(), 32'd2);
      if (a_q.size() == 2) begin
         chk("rd16_a0", {14'b0, a_q[0]}, 32'd8);
         chk("rd16_a1", {14'b0, a_q[1]}, 32'd9);
      end

      // table of 16-bit accesses
      for (int i = 0; i < 12; i++) begin
         xact(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, 0, e, rd);
         chk($sformatf("vec%0d_edge", i), e, vecs[i].exp_edge);
         if (!vecs[i].rw) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end

      // single upper-beat write, lower byte lane only
      xact(1'b0, 1'b1, 32'h30, 32'hDEADBEEF, 4'b0100, 0, e, rd);
      chk("wr1_edge", e, 32'd4);
      chk("wr1_nbeats", a_q.size(), 32'd1);
      if (a_q.size() == 1) begin
         chk("wr1_a", {14'b0, a_q[0]}, 32'd25);
         chk("wr1_dw", {16'b0, d_q[0]}, 32'h0000DEAD);
      end
      chk("wr1_lb", {31'b0, beat_lb}, 32'd0);
      chk("wr1_ub", {31'b0, beat_ub}, 32'd1);
      chk("wr1_drw", {31'b0, beat_drw}, 32'd1);
      chk("wr1_we_cycles", we_lo, 32'd1);

      // 8-bit instance: four-beat write then read back
      xact(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, 0, e, rd);
      chk("wr8_edge", e, 32'd13);
      chk("wr8_nbeats", a_q.size(), 32'd4);
      chk("wr8_we_cycles", we_lo, 32'd4);
      if (a_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr8_a%0d", i), {14'b0, a_q[i]}, 32'd32 + i);
            chk($sformatf("wr8_dw%0d", i), {16'b0, d_q[i]}, {24'b0, exp8[i]});
         end
      end
      xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, e, rd);
      chk("rd8_edge", e, 32'd13);
      chk("rd8_data", rd, 32'hDEADBEEF);

      // reset during beat 0 cycle 1 of a write
      sel8 = 1'b0; rw = 1'b1; addr = 32'h40; wdata = 32'h0BAD0BAD; wmask = 4'hF; req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_we_before_rst", {31'b0, mon_we}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_we_at_rst", {31'b0, mon_we}, 32'd1);
      chk("mid_ce_at_rst", {31'b0, mon_ce}, 32'd1);
      chk("mid_ready_at_rst", {31'b0, mon_ready}, 32'd0);
      rst_n = 1'b1;
      req = 1'b0;
      @(negedge clk);
      xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, e, rd);
      chk("post_rst_edge", e, 32'd7);
      chk("post_rst_data", rd, 32'hABCD1234);

      // repeated read of the same word, then write + read of it
      xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, e, rd);
`ifdef SRAM_READ_BUFFER_EN
      chk("reread_edge", e, 32'd1);
      chk("reread_ce_cycles", ce_lo, 32'd0);
`else
      chk("reread_edge", e, 32'd7);
      chk("reread_ce_cycles", ce_lo, 32'd6);
`endif
      chk("reread_data", rd, 32'hABCD1234);
      xact(1'b0, 1'b1, 32'h10, 32'h00005678, 4'b0011, 0, e, rd);
      chk("wr_a_edge", e, 32'd4);
      xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, e, rd);
      chk("rd_after_wr_edge", e, 32'd7);
      chk("rd_after_wr_ce_cycles", ce_lo, 32'd6);
      chk("rd_after_wr_data", rd, 32'hABCD5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
